// File: rtl/ddr_sim_pkg.sv
// Shared definitions for the behavioural DDR memory model: command codes, FSM states and
// the byte-strobe expansion helper.
package ddr_sim_pkg;

    localparam logic CMD_WRITE = 1'b0;
    localparam logic CMD_READ  = 1'b1;

    typedef enum logic [1:0] {
        ST_INIT,
        ST_RUN,
        ST_REFRESH
    } state_e;

    // One strobe bit covers one byte lane of the data word.
    function automatic logic [7:0] strb_to_mask(input logic strb);
        return {8{strb}};
    endfunction

endpackage

// File: rtl/ddr_sim_rd_pipe.sv
// Fixed-latency read return pipe: valid/data shift register, each stage holds its data
// until new valid data arrives so the output word stays put between pulses.
module ddr_sim_rd_pipe #(
    parameter int unsigned DATA_WIDTH = 256,
    parameter int unsigned RD_LATENCY = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  in_valid_i,
    input  logic [DATA_WIDTH-1:0] in_data_i,
    output logic                  out_valid_o,
    output logic [DATA_WIDTH-1:0] out_data_o
);

    logic [RD_LATENCY-1:0] valid_q;
    logic [DATA_WIDTH-1:0] data_q [RD_LATENCY];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= '0;
            for (int i = 0; i < int'(RD_LATENCY); i++) begin
                data_q[i] <= '0;
            end
        end else begin
            valid_q[0] <= in_valid_i;
            if (in_valid_i) begin
                data_q[0] <= in_data_i;
            end
            for (int i = 1; i < int'(RD_LATENCY); i++) begin
                valid_q[i] <= valid_q[i-1];
                if (valid_q[i-1]) begin
                    data_q[i] <= data_q[i-1];
                end
            end
        end
    end

    assign out_valid_o = valid_q[RD_LATENCY-1];
    assign out_data_o  = data_q[RD_LATENCY-1];

endmodule

// File: rtl/ddr_sim_mem_model.sv
// Behavioural DDR3 app-side memory model: calibration delay, periodic refresh stalls,
// byte-strobed writes and in-order fixed-latency reads.
module ddr_sim_mem_model
    import ddr_sim_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 256,
    parameter int unsigned ADDR_WIDTH     = 29,
    parameter int unsigned DEPTH_LOG2     = 10,
    parameter int unsigned RD_LATENCY     = 8,
    parameter int unsigned INIT_CYCLES    = 64,
    parameter int unsigned REFRESH_PERIOD = 780,
    parameter int unsigned REFRESH_CYCLES = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    output logic                    init_calib_complete_o,
    output logic                    cmd_ready_o,
    output logic                    wr_data_ready_o,
    input  logic                    cmd_en_i,
    input  logic                    cmd_i,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr_i,
    input  logic [DATA_WIDTH-1:0]   wr_data_i,
    input  logic [DATA_WIDTH/8-1:0] wr_strb_i,
    output logic                    rd_data_valid_o,
    output logic [DATA_WIDTH-1:0]   rd_data_o
);

    localparam int unsigned StrbW = DATA_WIDTH / 8;
    localparam int unsigned Lsb   = $clog2(StrbW);
    localparam int unsigned Depth = 2 ** DEPTH_LOG2;

    state_e      state_q;
    logic [31:0] cnt_q;
    logic        cmd_ready_q;
    logic        calib_q;

    // 2-state storage starts zero-filled and is deliberately untouched by reset.
    bit   [DATA_WIDTH-1:0] mem [Depth];

    logic [DEPTH_LOG2-1:0] word_idx;
    logic                  accept;
    logic                  wr_accept;
    logic                  rd_accept;
    logic [DATA_WIDTH-1:0] wr_mask;
    logic                  unused_addr;

    assign word_idx    = cmd_addr_i[Lsb +: DEPTH_LOG2];
    assign accept      = cmd_en_i & cmd_ready_q;
    assign wr_accept   = accept & (cmd_i == CMD_WRITE);
    assign rd_accept   = accept & (cmd_i == CMD_READ);
    assign unused_addr = ^cmd_addr_i;

    always_comb begin
        wr_mask = '0;
        for (int b = 0; b < int'(StrbW); b++) begin
            wr_mask[8*b +: 8] = strb_to_mask(wr_strb_i[b]);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_INIT;
            cnt_q       <= '0;
            cmd_ready_q <= 1'b0;
            calib_q     <= 1'b0;
        end else begin
            unique case (state_q)
                ST_INIT: begin
                    if (cnt_q == INIT_CYCLES - 1) begin
                        state_q     <= ST_RUN;
                        cnt_q       <= '0;
                        cmd_ready_q <= 1'b1;
                        calib_q     <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 32'd1;
                    end
                end
                ST_RUN: begin
                    if (REFRESH_PERIOD != 0) begin
                        if (cnt_q == REFRESH_PERIOD - 1) begin
                            state_q     <= ST_REFRESH;
                            cnt_q       <= '0;
                            cmd_ready_q <= 1'b0;
                        end else begin
                            cnt_q <= cnt_q + 32'd1;
                        end
                    end
                end
                ST_REFRESH: begin
                    if (cnt_q == REFRESH_CYCLES - 1) begin
                        state_q     <= ST_RUN;
                        cnt_q       <= '0;
                        cmd_ready_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 32'd1;
                    end
                end
                default: begin
                    state_q     <= ST_INIT;
                    cnt_q       <= '0;
                    cmd_ready_q <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_accept) begin
            mem[word_idx] <= (mem[word_idx] & ~wr_mask) | (wr_data_i & wr_mask);
        end
    end

    ddr_sim_rd_pipe #(
        .DATA_WIDTH(DATA_WIDTH),
        .RD_LATENCY(RD_LATENCY)
    ) u_rd_pipe (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .in_valid_i (rd_accept),
        .in_data_i  (mem[word_idx]),
        .out_valid_o(rd_data_valid_o),
        .out_data_o (rd_data_o)
    );

    assign init_calib_complete_o = calib_q;
    assign cmd_ready_o           = cmd_ready_q;
    assign wr_data_ready_o       = cmd_ready_q;

    always @(posedge clk_i) begin
        if (rst_ni && cmd_en_i && cmd_ready_q) begin
            assert (!$isunknown({cmd_i, cmd_addr_i}))
            else $error("ddr_sim_mem_model: unknown cmd/cmd_addr on accepted command");
            if (cmd_i == CMD_WRITE) begin
                assert (!$isunknown(wr_strb_i))
                else $error("ddr_sim_mem_model: unknown wr_strb on accepted write");
            end
        end
    end

endmodule

// File: tb/tb_ddr_sim_mem_model.sv
// Directed bench: calibration delay, strobed writes, read latency/order, address aliasing,
// refresh stalls (second instance) and reset with reads in flight.
module tb_ddr_sim_mem_model;

    localparam int unsigned RdLat = 8;
    localparam int unsigned InitC = 64;

    logic         clk;
    logic         rst_n;
    logic         en, cmd;
    logic [28:0]  addr;
    logic [255:0] wdata;
    logic [31:0]  strb;
    logic         calib, rdy, wrdy, vld;
    logic [255:0] rdata;

    logic         en_r;
    logic         calib_r, rdy_r, wrdy_r, vld_r;
    logic [255:0] rdata_r;

    int checks = 0;
    int errors = 0;

    ddr_sim_mem_model #(
        .RD_LATENCY    (RdLat),
        .INIT_CYCLES   (InitC),
        .REFRESH_PERIOD(0)
    ) dut (
        .clk_i                (clk),
        .rst_ni               (rst_n),
        .init_calib_complete_o(calib),
        .cmd_ready_o          (rdy),
        .wr_data_ready_o      (wrdy),
        .cmd_en_i             (en),
        .cmd_i                (cmd),
        .cmd_addr_i           (addr),
        .wr_data_i            (wdata),
        .wr_strb_i            (strb),
        .rd_data_valid_o      (vld),
        .rd_data_o            (rdata)
    );

    ddr_sim_mem_model #(
        .RD_LATENCY    (RdLat),
        .INIT_CYCLES   (4),
        .REFRESH_PERIOD(20),
        .REFRESH_CYCLES(4)
    ) dut_r (
        .clk_i                (clk),
        .rst_ni               (rst_n),
        .init_calib_complete_o(calib_r),
        .cmd_ready_o          (rdy_r),
        .wr_data_ready_o      (wrdy_r),
        .cmd_en_i             (en_r),
        .cmd_i                (1'b1),
        .cmd_addr_i           (29'h0),
        .wr_data_i            (256'h0),
        .wr_strb_i            (32'h0),
        .rd_data_valid_o      (vld_r),
        .rd_data_o            (rdata_r)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s: got %h required %h", tag, got, exp);
        end
    endtask

    // Entered and left at a negedge.
    task automatic wr(input logic [28:0] a, input logic [255:0] d, input logic [31:0] s);
        en = 1'b1; cmd = 1'b0; addr = a; wdata = d; strb = s;
        @(posedge clk);
        @(negedge clk);
        en = 1'b0;
    endtask

    task automatic rd_check(input string tag, input logic [28:0] a, input logic [255:0] exp);
        int j;
        en = 1'b1; cmd = 1'b1; addr = a;
        @(posedge clk);
        @(negedge clk);
        en = 1'b0;
        j = 0;
        while (!vld && j < 40) begin
            @(negedge clk);
            j++;
        end
        chk({tag, " latency"}, 256'(j), 256'(RdLat - 1));
        chk({tag, " data"}, rdata, exp);
    endtask

    initial begin
        int mism, got, first, last, bad, lows, vc, j;
        logic [31:0]  w;
        logic [255:0] a5;

        a5 = {8{32'hA5A5_0001}};
        rst_n = 1'b0; en_r = 1'b0;
        en = 1'b1; cmd = 1'b0; addr = 29'h1000; wdata = '1; strb = '1;

        // 1: reset state and calibration delay with a write held pending
        repeat (2) @(negedge clk);
        chk("reset ready", 256'(rdy), 256'(0));
        chk("reset calib", 256'(calib), 256'(0));
        chk("reset valid", 256'(vld), 256'(0));
        chk("reset rdata", rdata, 256'h0);
        rst_n = 1'b1;
        mism = 0;
        for (int k = 1; k <= int'(InitC); k++) begin
            @(negedge clk);
            if (rdy !== 1'(k == int'(InitC))) mism++;
            if (wrdy !== 1'(k == int'(InitC))) mism++;
        end
        en = 1'b0;
        chk("init ready timing", 256'(mism), 256'(0));
        chk("init calib", 256'(calib), 256'(1));
        rd_check("no early write", 29'h1000, 256'h0);

        // 2: full write then back-to-back read
        wr(29'h40, a5, '1);
        rd_check("full write", 29'h40, a5);

        // 3: partial and empty strobes
        wr(29'h80, '1, 32'h0000_000F);
        rd_check("strb low 4", 29'h80, 256'hFFFF_FFFF);
        wr(29'h80, {8{32'h1234_5678}}, 32'h0);
        rd_check("strb zero", 29'h80, 256'hFFFF_FFFF);

        // address aliasing: ignored low bits, wrapped high bits
        rd_check("low bits ignored", 29'h5F, a5);
        rd_check("high bits alias", 29'h8040, a5);

        // 4: 16 back-to-back reads
        for (int i = 0; i < 16; i++) begin
            w = 32'h1000 + 32'(i);
            wr(29'h200 + 29'(i * 32), {8{w}}, '1);
        end
        got = 0; first = -1; last = -1; bad = 0;
        for (int c = 0; c < 16 + int'(RdLat) + 4; c++) begin
            if (vld) begin
                if (got == 0) first = c;
                last = c;
                w = 32'h1000 + 32'(got);
                if (rdata !== {8{w}}) bad++;
                got++;
            end
            if (c < 16) begin
                en = 1'b1; cmd = 1'b1; addr = 29'h200 + 29'(c * 32);
            end else begin
                en = 1'b0;
            end
            @(negedge clk);
        end
        chk("burst count", 256'(got), 256'(16));
        chk("burst first latency", 256'(first), 256'(RdLat));
        chk("burst no gaps", 256'(last - first), 256'(15));
        chk("burst order data", 256'(bad), 256'(0));

        // 5: refresh stalls on the second instance, continuous reads
        j = 0;
        while (rdy_r && j < 100) begin @(negedge clk); j++; end
        while (!rdy_r && j < 200) begin @(negedge clk); j++; end
        chk("refresh sync", 256'(j < 200), 256'(1));
        en_r = 1'b1; bad = 0; lows = 0; vc = 0;
        for (int t = 0; t < 120; t++) begin
            if (rdy_r !== 1'((t % 24) < 20)) bad++;
            if (rdy_r === 1'b0) lows++;
            if (vld_r) vc++;
            @(negedge clk);
        end
        en_r = 1'b0;
        for (int t = 0; t < 20; t++) begin
            if (vld_r) vc++;
            @(negedge clk);
        end
        chk("refresh pattern", 256'(bad), 256'(0));
        chk("refresh low cycles", 256'(lows), 256'(20));
        chk("refresh reads returned", 256'(vc), 256'(100));

        // 6: reset with reads in flight; memory must persist
        wr(29'h3000, {8{32'hC0DE_0006}}, '1);
        en = 1'b1; cmd = 1'b1; addr = 29'h3000;
        repeat (3) @(negedge clk);
        en = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("mid reset ready", 256'(rdy), 256'(0));
        chk("mid reset calib", 256'(calib), 256'(0));
        chk("mid reset valid", 256'(vld), 256'(0));
        vc = 0;
        for (int t = 0; t < 3; t++) begin
            @(negedge clk);
            if (vld) vc++;
        end
        rst_n = 1'b1;
        j = 0;
        while (!rdy && j < 200) begin
            if (vld) vc++;
            @(negedge clk);
            j++;
        end
        chk("no valid after reset", 256'(vc), 256'(0));
        chk("reinit delay", 256'(j), 256'(InitC));
        rd_check("memory persisted", 29'h3000, {8{32'hC0DE_0006}});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
